// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word loader.
// Optional feature macro: UART_PARITY_EN (adds even-parity states).
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 10417;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_word_loader_if.sv
// Registered memory read port of the UART word loader.
interface uart_word_loader_if
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = DATA_BITS * 4
);
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;

    modport master (output RD_ADDR, input RD_DATA);
    modport slave  (input RD_ADDR, output RD_DATA);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: input synchroniser plus RX FSM, emits one-cycle byte/error pulses.
// Optional feature macro: UART_PARITY_EN (8E1 framing with parity check).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 byte_valid,
`ifdef UART_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 frame_err
);
    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);

    logic                 sync_q1;
    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_PARITY_EN
    logic                 par_bad;
`endif

    assign data = shift;

    // Two-flop synchroniser; idle-high so reset does not fake a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= rxd;
            rx_s    <= sync_q1;
        end
    end

    // Frame FSM: mid-bit sampling, glitch rejection on the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == CNT_MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bad <= (rx_s != ^shift);
                        state   <= RX_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
`ifdef UART_PARITY_EN
                        parity_err <= par_bad;
                        byte_valid <= rx_s && !par_bad;
`else
                        byte_valid <= rx_s;
`endif
                        frame_err  <= !rx_s;
                        state      <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// UART boot loader: assembles received bytes little-endian into words,
// stores them sequentially, echoes each byte, exposes a registered read port.
// Optional feature macro: UART_PARITY_EN (8E1 framing, PARITY_ERR port).
module uart_word_loader
    import uart_pkg::*;
#(
    parameter  int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter  int unsigned WORD_BYTES   = 4,
    parameter  int unsigned DEPTH        = 256,
    localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_RXD,
    output logic              UART_TXD,
    input  logic              CLEAR,
    uart_word_loader_if.slave rd,
    output logic [ADDR_W:0]   WORD_COUNT,
    output logic              FULL,
    output logic              FRAME_ERR,
`ifdef UART_PARITY_EN
    output logic              PARITY_ERR,
`endif
    output logic              OVERFLOW
);
    localparam int unsigned      DATA_W   = DATA_BITS * WORD_BYTES;
    localparam int unsigned      BIDX_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [DATA_BITS-1:0] rx_data;
    logic                 byte_valid;
    logic                 frame_err_p;
`ifdef UART_PARITY_EN
    logic                 parity_err_p;
    logic                 tx_par;
`endif

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    word_buf;
    logic [DATA_W-1:0]    word_next;
    logic [BIDX_W-1:0]    byte_idx;
    logic [BIDX_W-1:0]    idx_eff;
    logic [ADDR_W:0]      count_eff;
    logic [ADDR_W:0]      count_inc;
    logic                 full_eff;
    logic                 last_byte;
    logic                 store_word;

    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;
    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (CLK),
        .rst        (RST),
        .rxd        (UART_RXD),
        .data       (rx_data),
        .byte_valid (byte_valid),
`ifdef UART_PARITY_EN
        .parity_err (parity_err_p),
`endif
        .frame_err  (frame_err_p)
    );

    // Effective assembler view this cycle; CLEAR makes an arriving byte land as byte 0 of word 0.
    always_comb begin
        idx_eff   = CLEAR ? '0 : byte_idx;
        count_eff = CLEAR ? '0 : WORD_COUNT;
        full_eff  = CLEAR ? 1'b0 : FULL;
        word_next = CLEAR ? '0 : word_buf;
        for (int k = 0; k < int'(WORD_BYTES); k++) begin
            if (idx_eff == BIDX_W'(k)) word_next[DATA_BITS*k +: DATA_BITS] = rx_data;
        end
        count_inc  = count_eff + (ADDR_W+1)'(1);
        last_byte  = (idx_eff == BIDX_W'(WORD_BYTES - 1));
        store_word = byte_valid && !full_eff && last_byte;
    end

    // Word assembly, write pointer and sticky status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            word_buf   <= '0;
            byte_idx   <= '0;
            WORD_COUNT <= '0;
            FULL       <= 1'b0;
            OVERFLOW   <= 1'b0;
            FRAME_ERR  <= 1'b0;
`ifdef UART_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            if (frame_err_p) FRAME_ERR <= 1'b1;
`ifdef UART_PARITY_EN
            if (parity_err_p) PARITY_ERR <= 1'b1;
`endif
            if (CLEAR) begin
                word_buf   <= '0;
                byte_idx   <= '0;
                WORD_COUNT <= '0;
                FULL       <= 1'b0;
            end
            if (byte_valid) begin
                if (full_eff) begin
                    OVERFLOW <= 1'b1;
                end else if (last_byte) begin
                    word_buf   <= '0;
                    byte_idx   <= '0;
                    WORD_COUNT <= count_inc;
                    FULL       <= (count_inc == (ADDR_W+1)'(DEPTH));
                end else begin
                    word_buf <= word_next;
                    byte_idx <= idx_eff + BIDX_W'(1);
                end
            end
        end
    end

    // Word memory; contents survive reset and CLEAR.
    always_ff @(posedge CLK) begin
        if (store_word) mem[count_eff[ADDR_W-1:0]] <= word_next;
    end

    // Registered read port; read-before-write on address collision.
    always_ff @(posedge CLK) begin
        if (RST) rd.RD_DATA <= '0;
        else     rd.RD_DATA <= mem[rd.RD_ADDR];
    end

    // Echo path: one-entry holding register feeding the TX frame FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            UART_TXD   <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (hold_valid) begin
                        tx_shift   <= hold_data;
`ifdef UART_PARITY_EN
                        tx_par     <= ^hold_data;
`endif
                        hold_valid <= 1'b0;
                        UART_TXD   <= 1'b0;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        UART_TXD <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            UART_TXD <= tx_par;
                            tx_state <= TX_PARITY;
`else
                            UART_TXD <= 1'b1;
                            tx_state <= TX_STOP;
`endif
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            UART_TXD <= tx_shift[1];
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        UART_TXD <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
            if (byte_valid && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader (CLKS_PER_BIT=16, WORD_BYTES=4, DEPTH=2).
// Build with UART_PARITY_EN defined to also exercise the 8E1 variant.
module tb_uart_word_loader;
    import uart_pkg::*;

    localparam int unsigned CPB    = 16;
    localparam int unsigned WB     = 4;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ADDR_W = 1;
    localparam int unsigned DW     = 32;
    localparam int unsigned GAP    = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            UART_RXD = 1'b1;
    logic            CLEAR = 1'b0;
    logic            UART_TXD;
    logic [ADDR_W:0] WORD_COUNT;
    logic            FULL;
    logic            FRAME_ERR;
    logic            OVERFLOW;
`ifdef UART_PARITY_EN
    logic            PARITY_ERR;
`endif

    uart_word_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DW)) rd_if ();

    uart_word_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .UART_RXD   (UART_RXD),
        .UART_TXD   (UART_TXD),
        .CLEAR      (CLEAR),
        .rd         (rd_if),
        .WORD_COUNT (WORD_COUNT),
        .FULL       (FULL),
        .FRAME_ERR  (FRAME_ERR),
`ifdef UART_PARITY_EN
        .PARITY_ERR (PARITY_ERR),
`endif
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          exp_count = 0;
    bit          exp_full  = 1'b0;
    bit          exp_ferr  = 1'b0;
    bit          exp_ovf   = 1'b0;
    bit          exp_perr  = 1'b0;
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_word = '0;
    int          mdl_idx  = 0;
    logic [7:0]  exp_echo [$];
    logic [7:0]  got_echo [$];
    bit          check_en = 1'b0;
    bit          mon_en   = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted byte is echoed; it is stored unless the memory is full.
    task automatic model_byte(input logic [7:0] b);
        exp_echo.push_back(b);
        if (exp_full) begin
            exp_ovf = 1'b1;
        end else begin
            mdl_word[8*mdl_idx +: 8] = b;
            mdl_idx++;
            if (mdl_idx == int'(WB)) begin
                mdl_mem[exp_count] = mdl_word;
                exp_count++;
                mdl_idx  = 0;
                mdl_word = '0;
                exp_full = (exp_count == int'(DEPTH));
            end
        end
    endtask

    task automatic model_clear();
        exp_count = 0;
        exp_full  = 1'b0;
        mdl_idx   = 0;
        mdl_word  = '0;
    endtask

    task automatic model_reset();
        model_clear();
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        exp_perr = 1'b0;
    endtask

    // Status outputs must match the model whenever no frame is in flight.
    always @(negedge CLK) begin
        if (check_en) begin
            check("word_count", 64'(WORD_COUNT), 64'(exp_count));
            check("full",       64'(FULL),       64'(exp_full));
            check("frame_err",  64'(FRAME_ERR),  64'(exp_ferr));
            check("overflow",   64'(OVERFLOW),   64'(exp_ovf));
`ifdef UART_PARITY_EN
            check("parity_err", 64'(PARITY_ERR), 64'(exp_perr));
`endif
        end
    end

    // Echo decoder: samples UART_TXD at mid-bit and collects bytes.
    initial begin
        logic [7:0] d;
        forever begin
            @(negedge CLK);
            if (UART_TXD == 1'b0 && !RST) begin
                repeat (CPB / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    d[i] = UART_TXD;
                end
`ifdef UART_PARITY_EN
                repeat (CPB) @(negedge CLK);
                if (mon_en) check("echo_parity", 64'(UART_TXD), 64'(^d));
`endif
                repeat (CPB) @(negedge CLK);
                if (mon_en) begin
                    check("echo_stop", 64'(UART_TXD), 64'(1));
                    got_echo.push_back(d);
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        UART_RXD = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad);
        check_en = 1'b0;
        @(negedge CLK);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit((^b) ^ par_bad);
        if (par_bad) exp_perr = 1'b1;
`endif
        drive_bit(stop_ok);
        UART_RXD = 1'b1;
        if (!stop_ok) exp_ferr = 1'b1;
        if (stop_ok && !par_bad) model_byte(b);
        @(negedge CLK);
        check_en = 1'b1;
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0);
    endtask

    task automatic read_check(input logic [ADDR_W-1:0] addr, input logic [31:0] lit);
        @(negedge CLK);
        rd_if.RD_ADDR = addr;
        @(negedge CLK);
        check("rd_data_lit",   64'(rd_if.RD_DATA), 64'(lit));
        check("rd_data_model", 64'(rd_if.RD_DATA), 64'(mdl_mem[addr]));
    endtask

    task automatic do_clear();
        check_en = 1'b0;
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        model_clear();
        @(negedge CLK);
        check_en = 1'b1;
    endtask

    task automatic drain_echo();
        repeat (12 * CPB) @(negedge CLK);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_txd"},   64'(UART_TXD),      64'(1));
        check({tag, "_rd"},    64'(rd_if.RD_DATA), 64'(0));
        check({tag, "_count"}, 64'(WORD_COUNT),    64'(0));
        check({tag, "_full"},  64'(FULL),          64'(0));
        check({tag, "_ferr"},  64'(FRAME_ERR),     64'(0));
        check({tag, "_ovf"},   64'(OVERFLOW),      64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_if.RD_ADDR = '0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        check_en = 1'b1;

        // First word, little-endian assembly
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("first_word_count", 64'(WORD_COUNT), 64'(1));
        read_check(1'b0, 32'h12345678);

        // Short low glitch is rejected
        @(negedge CLK);
        UART_RXD = 1'b0;
        repeat (3) @(negedge CLK);
        UART_RXD = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
        check("glitch_count", 64'(WORD_COUNT), 64'(1));

        // Framing error, then next byte starts word 1
        send_frame(8'hA5, 1'b0, 1'b0);
        check("frame_err_set", 64'(FRAME_ERR), 64'(1));
        repeat (2 * CPB) @(negedge CLK);
        send_byte(8'h3C); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("second_word_full", 64'(FULL), 64'(1));
        read_check(1'b1, 32'h3322113C);
        read_check(1'b0, 32'h12345678);

        // Fill and overflow from a fresh reset
        drain_echo();
        check_en = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        check_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'h10 + 8'(i));
            if (i == 7) begin
                check("full_after_8", 64'(FULL), 64'(1));
                check("no_ovf_at_8",  64'(OVERFLOW), 64'(0));
            end
            if (i == 8) check("ovf_at_9", 64'(OVERFLOW), 64'(1));
        end
        read_check(1'b0, 32'h13121110);
        read_check(1'b1, 32'h17161514);

        // CLEAR discards a partial word, keeps memory and sticky flags
        do_clear();
        send_byte(8'hAA); send_byte(8'hBB);
        do_clear();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("clear_count", 64'(WORD_COUNT), 64'(1));
        check("clear_keeps_ovf", 64'(OVERFLOW), 64'(1));
        read_check(1'b0, 32'h04030201);
        read_check(1'b1, 32'h17161514);

`ifdef UART_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        do_clear();
        send_frame(8'h07, 1'b1, 1'b1);
        check("parity_err_set", 64'(PARITY_ERR), 64'(1));
        send_byte(8'h07);
`endif

        // Echo stream must be every accepted byte, in order
        drain_echo();
        check("echo_count", 64'(got_echo.size()), 64'(exp_echo.size()));
        for (int i = 0; i < exp_echo.size() && i < got_echo.size(); i++)
            check("echo_byte", 64'(got_echo[i]), 64'(exp_echo[i]));
        mon_en = 1'b0;

        // Reset in the middle of a frame while an echo is in flight
        check_en = 1'b0;
        @(negedge CLK);
        UART_RXD = 1'b0;
        repeat (3 * CPB) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_values("midframe_rst");
        UART_RXD = 1'b1;
        RST = 1'b0;
        model_reset();
        repeat (24 * CPB) @(negedge CLK);
        check_en = 1'b1;
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        read_check(1'b0, 32'hDEADBEEF);

        check_en = 1'b0;
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
